// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Holds the access-size encodings, the FSM state type and the latched request layout.
package dmem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        unsigned_ld;
  } dmem_req_t;

  // Byte accesses have no alignment restriction; a reserved size is not flagged here.
  function automatic logic is_misaligned(input logic [31:0] addr, input logic [1:0] size);
    logic r;
    case (size)
      SZ_WORD: r = (addr[1:0] != 2'b00);
      SZ_HALF: r = addr[0];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Produces a one-hot grant; the search starts just after the previous winner.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_last_grant,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_grant_id,
  output logic            o_any
);

  always_comb begin
    int unsigned w_idx;
    w_idx      = 0;
    o_grant    = '0;
    o_grant_id = '0;
    o_any      = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_idx = 32'(i_last_grant) + k;
      if (w_idx >= NREQ) begin
        w_idx = w_idx - NREQ;
      end
      // Constant-index compare keeps the select lint-clean for any NREQ.
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!o_any && (j == w_idx) && i_req[j]) begin
          o_grant[j] = 1'b1;
          o_grant_id = IDW'(j);
          o_any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a single-port data memory among NREQ valid/ready requesters.
// One request in flight: IDLE accepts, ACCESS drives the memory once, RESP holds the tagged reply.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned IDW       = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NREQ-1:0]   i_req_valid,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic [NREQ-1:0]   i_req_we,
  input  logic [NREQ*32-1:0] i_req_addr,
  input  logic [NREQ*32-1:0] i_req_wdata,
  input  logic [NREQ*2-1:0] i_req_size,
  input  logic [NREQ-1:0]   i_req_unsigned,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [IDW-1:0]    o_rsp_id,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_mem_we,
  output logic [31:0]       o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_mem_datatype,
  output logic [1:0]        o_mem_datasize,
  input  logic [31:0]       i_mem_rdata
);

  state_e          r_state, w_state_next;
  logic [IDW-1:0]  r_last_grant, r_id, w_grant_id;
  logic [NREQ-1:0] w_grant;
  logic            w_any, w_accept, w_err, w_load_ok;
  dmem_req_t       r_req, w_req_sel;
  logic [IDW-1:0]  r_rsp_id;
  logic [31:0]     r_rsp_rdata;
  logic            r_rsp_err;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .i_req        (i_req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_id   (w_grant_id),
    .o_any        (w_any)
  );

  always_comb begin
    w_req_sel = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_grant[i]) begin
        w_req_sel.we          = i_req_we[i];
        w_req_sel.addr        = i_req_addr[i*32 +: 32];
        w_req_sel.wdata       = i_req_wdata[i*32 +: 32];
        w_req_sel.size        = i_req_size[i*2 +: 2];
        w_req_sel.unsigned_ld = i_req_unsigned[i];
      end
    end
  end

  assign w_err = (r_req.size == 2'b11) || is_misaligned(r_req.addr, r_req.size) ||
                 (r_req.addr >= MEM_BYTES);
  assign w_load_ok = !r_req.we && !w_err;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    o_req_ready  = '0;
    o_mem_we     = 1'b0;
    o_rsp_valid  = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_any && !i_reset) begin
          o_req_ready  = w_grant;
          w_accept     = 1'b1;
          w_state_next = StAccess;
        end
      end
      StAccess: begin
        // Reset wins even inside the access cycle so an interrupted store never commits.
        o_mem_we     = r_req.we && !w_err && !i_reset;
        w_state_next = StResp;
      end
      StResp: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last_grant <= IDW'(NREQ - 1);
      r_id         <= '0;
      r_req        <= '0;
      r_rsp_id     <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_req        <= w_req_sel;
        r_id         <= w_grant_id;
        r_last_grant <= w_grant_id;
      end
      if (r_state == StAccess) begin
        r_rsp_id    <= r_id;
        r_rsp_err   <= w_err;
        r_rsp_rdata <= w_load_ok ? i_mem_rdata : 32'h0;
      end
    end
  end

  // Memory control lines come straight from the latched request, so they hold between accesses.
  assign o_mem_addr     = r_req.addr;
  assign o_mem_wdata    = r_req.wdata;
  assign o_mem_datasize = r_req.size;
  assign o_mem_datatype = r_req.unsigned_ld;
  assign o_rsp_id       = r_rsp_id;
  assign o_rsp_rdata    = r_rsp_rdata;
  assign o_rsp_err      = r_rsp_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: byte-array memory, byte-level reference model,
// directed scenarios followed by randomized traffic.
module tb_dmem_arbiter;

  localparam int NREQ = 2;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] flat_addr, flat_wdata;
  logic [NREQ*2-1:0] flat_size;
  logic [NREQ-1:0]   flat_we, flat_uns;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_we, mem_datatype;
  logic [31:0]       mem_addr, mem_wdata, mem_rdata;
  logic [1:0]        mem_datasize;

  logic        tb_we   [NREQ];
  logic [31:0] tb_addr [NREQ];
  logic [31:0] tb_wdata[NREQ];
  logic [1:0]  tb_size [NREQ];
  logic        tb_uns  [NREQ];

  logic [7:0] mem_b [256];
  logic [7:0] ref_b [256];
  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int m_last   = NREQ - 1;
  logic [31:0] obs_rdata;
  logic        obs_err;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .NREQ      (NREQ),
    .MEM_BYTES (256),
    .IDW       (IDW)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_we       (flat_we),
    .i_req_addr     (flat_addr),
    .i_req_wdata    (flat_wdata),
    .i_req_size     (flat_size),
    .i_req_unsigned (flat_uns),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_id       (rsp_id),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_err      (rsp_err),
    .o_mem_we       (mem_we),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .o_mem_datatype (mem_datatype),
    .o_mem_datasize (mem_datasize),
    .i_mem_rdata    (mem_rdata)
  );

  always_comb begin
    flat_we = '0; flat_uns = '0; flat_addr = '0; flat_wdata = '0; flat_size = '0;
    for (int i = 0; i < NREQ; i++) begin
      flat_we[i]             = tb_we[i];
      flat_uns[i]            = tb_uns[i];
      flat_addr[i*32 +: 32]  = tb_addr[i];
      flat_wdata[i*32 +: 32] = tb_wdata[i];
      flat_size[i*2 +: 2]    = tb_size[i];
    end
  end

  // Data memory: combinational extended read, write on the clock edge.
  always_comb begin
    int a;
    logic [31:0] w;
    a = int'(mem_addr[7:0]);
    w = {mem_b[(a + 3) % 256], mem_b[(a + 2) % 256], mem_b[(a + 1) % 256], mem_b[a]};
    case (mem_datasize)
      2'b00:   mem_rdata = w;
      2'b01:   mem_rdata = mem_datatype ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: mem_rdata = mem_datatype ? {24'h0, w[7:0]} : {{24{w[7]}}, w[7:0]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_we) begin
      we_cnt <= we_cnt + 1;
      for (int i = 0; i < 4; i++) begin
        if (i < ((mem_datasize == 2'b00) ? 4 : (mem_datasize == 2'b01) ? 2 : 1)) begin
          mem_b[(int'(mem_addr[7:0]) + i) % 256] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Reference: byte-addressed array, errors from the alignment/range/size rules.
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       output logic err, output logic [31:0] rd);
    int n;
    longint v;
    n   = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : 1;
    err = (size == 2'd3) || ((addr % n) != 0) || (addr >= 256);
    rd  = 32'h0;
    v   = 0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_b[int'(addr) + i] = wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) v = v | (longint'(ref_b[int'(addr) + i]) << (8 * i));
        if (!uns && v[8*n-1]) v = v - (longint'(1) << (8 * n));
        rd = v[31:0];
      end
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] vmask);
    for (int k = 1; k <= NREQ; k++) begin
      if (vmask[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_req(input int r, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input logic uns);
    tb_we[r] = we; tb_addr[r] = addr; tb_wdata[r] = wdata; tb_size[r] = size; tb_uns[r] = uns;
  endtask

  task automatic txn(input logic [NREQ-1:0] vmask, input int stall, output int gid);
    logic err, exp_we;
    logic [31:0] rd;
    int g, we0;
    g = rr_pick(vmask);
    @(negedge clk);
    req_valid = vmask;
    #1;
    check_eq("ready_grant", 32'(req_ready), 32'(1 << g));
    model(tb_we[g], tb_addr[g], tb_wdata[g], tb_size[g], tb_uns[g], err, rd);
    exp_we = tb_we[g] && !err;
    we0 = we_cnt;
    @(negedge clk);
    #1;
    check_eq("access_ready", 32'(req_ready), 32'h0);
    check_eq("access_mem_we", 32'(mem_we), 32'(exp_we));
    check_eq("access_mem_addr", mem_addr, tb_addr[g]);
    for (int c = 0; c <= stall; c++) begin
      @(negedge clk);
      rsp_ready = (c == stall);
      #1;
      if (c == 0) begin
        obs_rdata = rsp_rdata;
        obs_err   = rsp_err;
      end
      check_eq("rsp_valid", 32'(rsp_valid), 32'h1);
      check_eq("rsp_id", 32'(rsp_id), 32'(g));
      check_eq("rsp_rdata", rsp_rdata, rd);
      check_eq("rsp_err", 32'(rsp_err), 32'(err));
      check_eq("resp_ready", 32'(req_ready), 32'h0);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = '0;
    #1;
    check_eq("rsp_drop", 32'(rsp_valid), 32'h0);
    check_eq("we_pulses", 32'(we_cnt - we0), 32'(exp_we));
    m_last = g;
    gid = g;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    logic [31:0] init_w;
    for (int i = 0; i < 256; i++) begin
      mem_b[i] = 8'($urandom);
      ref_b[i] = mem_b[i];
    end
    for (int r = 0; r < NREQ; r++) set_req(r, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    reset = 1'b1; req_valid = '1; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("rst_rsp_id", 32'(rsp_id), 32'h0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'h0);
    check_eq("rst_mem_we", 32'(mem_we), 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    check_eq("rst_mem_type", 32'(mem_datatype), 32'h0);
    check_eq("rst_mem_size", 32'(mem_datasize), 32'h0);
    @(negedge clk);
    reset = 1'b0; req_valid = '0;

    // Fairness with both requesters pending.
    set_req(0, 1'b0, 32'h40, 32'h0, 2'b00, 1'b0);
    set_req(1, 1'b0, 32'h44, 32'h0, 2'b00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      txn(2'b11, 0, g);
      check_eq("alt_grant", 32'(g), 32'(i % 2));
    end

    set_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 1'b0);
    txn(2'b01, 0, g);
    set_req(0, 1'b0, 32'h13, 32'h0, 2'b10, 1'b0);
    txn(2'b01, 0, g);
    check_eq("lb_signed", obs_rdata, 32'hFFFFFFDE);

    set_req(1, 1'b1, 32'h22, 32'h00008001, 2'b01, 1'b0);
    txn(2'b10, 0, g);
    set_req(1, 1'b0, 32'h22, 32'h0, 2'b01, 1'b1);
    txn(2'b10, 0, g);
    check_eq("lhu", obs_rdata, 32'h00008001);
    set_req(1, 1'b0, 32'h22, 32'h0, 2'b01, 1'b0);
    txn(2'b10, 0, g);
    check_eq("lh_signed", obs_rdata, 32'hFFFF8001);

    set_req(0, 1'b1, 32'h0C, 32'h12345678, 2'b00, 1'b0);
    txn(2'b01, 0, g);
    set_req(0, 1'b0, 32'h21, 32'h0, 2'b01, 1'b0);
    txn(2'b01, 0, g);
    check_eq("err_half_misal", 32'(obs_err), 32'h1);
    set_req(0, 1'b1, 32'h0E, 32'hCAFEF00D, 2'b00, 1'b0);
    txn(2'b01, 0, g);
    check_eq("err_word_misal", 32'(obs_err), 32'h1);
    set_req(0, 1'b1, 32'h0C, 32'hFFFFFFFF, 2'b11, 1'b0);
    txn(2'b01, 0, g);
    check_eq("err_size11", 32'(obs_err), 32'h1);
    set_req(0, 1'b1, 32'h100, 32'hFFFFFFFF, 2'b10, 1'b0);
    txn(2'b01, 0, g);
    check_eq("err_range", 32'(obs_err), 32'h1);
    check_eq("err_rdata", obs_rdata, 32'h0);
    set_req(0, 1'b0, 32'h0C, 32'h0, 2'b00, 1'b0);
    txn(2'b01, 0, g);
    check_eq("readback_0c", obs_rdata, 32'h12345678);

    // Long response back-pressure with both requesters still asking.
    set_req(1, 1'b0, 32'h10, 32'h0, 2'b00, 1'b0);
    txn(2'b11, 5, g);

    // Reset during the access cycle of a store.
    init_w = {ref_b[8'h33], ref_b[8'h32], ref_b[8'h31], ref_b[8'h30]};
    set_req(0, 1'b1, 32'h30, 32'h55AA55AA, 2'b00, 1'b0);
    g = we_cnt;
    @(negedge clk);
    req_valid = 2'b01;
    #1;
    check_eq("mid_rst_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    reset = 1'b1; req_valid = '0;
    #1;
    check_eq("mid_rst_mem_we", 32'(mem_we), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("mid_rst_no_rsp", 32'(rsp_valid), 32'h0);
      @(negedge clk);
    end
    check_eq("mid_rst_no_write", 32'(we_cnt - g), 32'h0);
    m_last = NREQ - 1;
    set_req(0, 1'b0, 32'h30, 32'h0, 2'b00, 1'b0);
    set_req(1, 1'b0, 32'h34, 32'h0, 2'b00, 1'b0);
    txn(2'b11, 0, g);
    check_eq("post_rst_grant", 32'(g), 32'h0);
    check_eq("post_rst_word", obs_rdata, init_w);

    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < NREQ; r++) begin
        int sel, nb;
        logic [1:0] sz;
        logic [31:0] a;
        sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        nb  = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
        sel = $urandom_range(0, 19);
        a   = (sel == 0) ? 32'(256 + $urandom_range(0, 300)) : 32'($urandom_range(0, 255));
        if (sel > 0 && sel < 15) a = a & ~32'(nb - 1);
        set_req(r, 1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)));
      end
      txn(NREQ'($urandom_range(1, 3)), $urandom_range(0, 3), g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
